// File: rtl/qspi_stream_scheduler_pkg.sv
// Shared types and constants for the QSPI video stream scheduler.
package qspi_sched_pkg;

    localparam int unsigned OCC_W      = 3;
    localparam int unsigned WORD_BYTES = 3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitStart,
        StStream,
        StStop,
        StWaitStop
    } sched_state_e;

endpackage

// File: rtl/qspi_stream_scheduler_if.sv
// Handshake bundle between the scheduler, the VGA/decoder side and the QSPI controller.
interface qspi_stream_scheduler_if #(
    parameter int unsigned ADDR_W = 24
);
    import qspi_sched_pkg::*;

    logic              enable;
    logic              frame_start;
    logic              word_valid;
    logic              word_pop;
    logic              cmd_ack;
    logic              cmd_start;
    logic              cmd_stop;
    logic [ADDR_W-1:0] cmd_addr;
    logic              fetch_en;
    logic [OCC_W-1:0]  occupancy;
    logic              underrun;
    logic [7:0]        loop_cnt;

    // Scheduler side
    modport master (
        input  enable, frame_start, word_valid, word_pop, cmd_ack,
        output cmd_start, cmd_stop, cmd_addr, fetch_en, occupancy, underrun, loop_cnt
    );

    // Environment side (timing/decoder plus QSPI controller)
    modport slave (
        output enable, frame_start, word_valid, word_pop, cmd_ack,
        input  cmd_start, cmd_stop, cmd_addr, fetch_en, occupancy, underrun, loop_cnt
    );

endinterface

// File: rtl/qspi_stream_scheduler_buffer_fill_tracker.sv
// Tracks words held in the instruction buffer chain and latches a sticky underrun flag.
module buffer_fill_tracker
    import qspi_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_word_valid,
    input  logic             i_word_pop,
    output logic [OCC_W-1:0] o_occupancy,
    output logic [OCC_W-1:0] o_occ_next,
    output logic             o_underrun
);

    logic [OCC_W-1:0] r_occ;
    logic             r_underrun;
    logic [OCC_W-1:0] w_occ_next;
    logic             w_underrun_set;

    always_comb begin
        w_occ_next = r_occ;
        unique case ({i_word_valid, i_word_pop})
            2'b10:   w_occ_next = (r_occ == OCC_W'(DEPTH)) ? r_occ : r_occ + 1'b1;
            2'b01:   w_occ_next = (r_occ == '0) ? r_occ : r_occ - 1'b1;
            default: w_occ_next = r_occ;
        endcase
    end

    // A pop against an empty chain is an underrun unless a word bypasses in the same cycle.
    assign w_underrun_set = i_word_pop && !i_word_valid && (r_occ == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ      <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_occ      <= w_occ_next;
            r_underrun <= r_underrun | w_underrun_set;
        end
    end

    assign o_occupancy = r_occ;
    assign o_occ_next  = w_occ_next;
    assign o_underrun  = r_underrun;

endmodule

// File: rtl/qspi_stream_scheduler.sv
// Starts, stops and resumes QSPI read bursts for the video stream and paces word fetches.
module qspi_stream_scheduler
    import qspi_sched_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       VIDEO_WORDS = 131072,
    parameter int unsigned       DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    qspi_stream_scheduler_if.master bus
);

    localparam int unsigned IDX_W = (VIDEO_WORDS > 2) ? $clog2(VIDEO_WORDS) : 1;

    sched_state_e      r_state;
    logic              r_cmd_start;
    logic              r_cmd_stop;
    logic              r_fetch_en;
    logic [IDX_W-1:0]  r_word_idx;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [7:0]        r_loop_cnt;

    logic [OCC_W-1:0]  w_occupancy;
    logic [OCC_W-1:0]  w_occ_next;
    logic              w_underrun;
    logic              w_last_word;
    logic              w_room;

    buffer_fill_tracker #(
        .DEPTH (DEPTH)
    ) u_fill (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_word_valid (bus.word_valid),
        .i_word_pop   (bus.word_pop),
        .o_occupancy  (w_occupancy),
        .o_occ_next   (w_occ_next),
        .o_underrun   (w_underrun)
    );

    assign w_last_word = (r_word_idx == IDX_W'(VIDEO_WORDS - 1));
    assign w_room      = (w_occ_next < OCC_W'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cmd_start <= 1'b0;
            r_cmd_stop  <= 1'b0;
            r_fetch_en  <= 1'b0;
            r_word_idx  <= '0;
            r_cmd_addr  <= BASE_ADDR;
            r_loop_cnt  <= '0;
        end else begin
            r_cmd_start <= 1'b0;
            r_cmd_stop  <= 1'b0;
            r_fetch_en  <= 1'b0;

            // Every delivered word advances the address, including stragglers in WAIT_STOP.
            if (bus.word_valid) begin
                if (w_last_word) begin
                    r_word_idx <= '0;
                    r_cmd_addr <= BASE_ADDR;
                    r_loop_cnt <= r_loop_cnt + 8'd1;
                end else begin
                    r_word_idx <= r_word_idx + 1'b1;
                    r_cmd_addr <= r_cmd_addr + ADDR_W'(WORD_BYTES);
                end
            end

            unique case (r_state)
                StIdle: begin
                    if (bus.frame_start && bus.enable) begin
                        r_state     <= StStart;
                        r_cmd_start <= 1'b1;
                    end
                end
                StStart: begin
                    r_state <= StWaitStart;
                end
                StWaitStart: begin
                    if (bus.cmd_ack) begin
                        r_state    <= StStream;
                        r_fetch_en <= w_room;
                    end
                end
                StStream: begin
                    if ((w_last_word && bus.word_valid) || !bus.enable) begin
                        r_state    <= StStop;
                        r_cmd_stop <= 1'b1;
                    end else begin
                        r_fetch_en <= w_room;
                    end
                end
                StStop: begin
                    r_state <= StWaitStop;
                end
                StWaitStop: begin
                    if (bus.cmd_ack) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.cmd_start = r_cmd_start;
    assign bus.cmd_stop  = r_cmd_stop;
    assign bus.cmd_addr  = r_cmd_addr;
    assign bus.fetch_en  = r_fetch_en;
    assign bus.occupancy = w_occupancy;
    assign bus.underrun  = w_underrun;
    assign bus.loop_cnt  = r_loop_cnt;

endmodule

// File: doc/qspi_stream_scheduler.md
Name: qspi_stream_scheduler

Overview:
Sequences QSPI flash reads for the video stream. It decides when a read burst starts, stops and resumes, and which flash address it uses. It also paces word fetches against free space in the 4-deep instruction buffer chain and flags underruns. It sits between the VGA timing/decoder side (frame start, pixel consumption) and the QSPI controller (command and shift handshake).

Parameters:
ADDR_W, 24, flash byte-address width
BASE_ADDR, 24'h000000, byte address of the first instruction word of the video
VIDEO_WORDS, 131072, instruction words per full video loop; must be ≥ 2
DEPTH, 4, buffer slots between QSPI controller and decoder
WORD_BYTES, 3, flash bytes per 18-bit instruction word (6 nibbles, upper 6 bits unused)

Ports:
clk  in  1  pixel clock (~25 MHz)
rst_n  in  1  asynchronous active-low reset
enable  in  1  stream enable (level); low requests orderly stop
frame_start  in  1  one-cycle pulse at vsync leading edge
word_valid  in  1  QSPI controller delivered one word into buffer (one pulse per word)
word_pop  in  1  decoder consumed one word from buffer head
cmd_ack  in  1  QSPI controller finished the command phase of cmd_start or cmd_stop
cmd_start  out  1  one-cycle pulse: begin continuous read at cmd_addr
cmd_stop  out  1  one-cycle pulse: terminate read (deassert CS)
cmd_addr  out  ADDR_W  byte address for cmd_start
fetch_en  out  1  QSPI controller may shift out the next word
occupancy  out  3  words currently held in buffer chain (0..DEPTH)
underrun  out  1  sticky: pop seen with empty buffer
loop_cnt  out  8  completed video loops, wraps 255→0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all pulses 0, fetch_en=0, occupancy=0, underrun=0, loop_cnt=0, word_idx=0, cmd_addr=BASE_ADDR. Reset mid-burst abandons the burst. The QSPI controller resets on the same rst_n.
- States:
  - IDLE → START on frame_start && enable.
  - START: cmd_start=1 for exactly one cycle, then → WAIT_START.
  - WAIT_START: → STREAM on cmd_ack.
  - STREAM:
    - word_idx == VIDEO_WORDS-1 && word_valid → STOP (end of loop).
    - !enable → STOP (pause).
  - STOP: cmd_stop=1 for one cycle, then → WAIT_STOP.
  - WAIT_STOP: on cmd_ack → IDLE.
- fetch_en is registered. It is 1 only in STREAM when next-cycle occupancy < DEPTH, i.e. (occupancy - word_pop + word_valid) < DEPTH. It drops in the same cycle STREAM exits.
- occupancy, updated every cycle:
  - word_valid && !word_pop: +1.
  - word_pop && !word_valid: -1.
  - both asserted: unchanged.
  - word_valid at DEPTH with no pop: protocol error. Saturate at DEPTH; assertion in bench.
- Underrun: word_pop with occupancy==0 and !word_valid sets underrun, which holds until reset. occupancy stays 0. Pop with occupancy==0 and word_valid in the same cycle is a bypass: no underrun, occupancy stays 0.
- Addressing:
  - word_valid increments word_idx and adds WORD_BYTES to cmd_addr. No multiplier.
  - End of loop: word_idx→0, cmd_addr→BASE_ADDR, loop_cnt+1.
  - Pause: word_idx and cmd_addr hold. The next START resumes at the first undelivered word.
- Words still buffered at a pause remain counted in occupancy; pops keep draining them in any state.
- Words arriving in WAIT_STOP (in flight before CS rose) are counted normally and advance the address.
- frame_start outside IDLE is ignored. The loop restarts only at a frame boundary, so VIDEO_WORDS must end on a frame.
- enable falling during START or WAIT_START: complete the start handshake, then enter STOP from STREAM on the next cycle.
- cmd_addr changes only while not in START/WAIT_START. The QSPI controller samples it on cmd_start.

Decomposition:
- Package qspi_sched_pkg: state enum (IDLE, START, WAIT_START, STREAM, STOP, WAIT_STOP), WORD_BYTES, OCC_W=3.
- One sub-module, buffer_fill_tracker: occupancy up/down counter, saturation, underrun sticky bit, next-occupancy output used for fetch_en.

Test Plan:
- Reset, enable=1, frame_start pulse → cmd_start one cycle later with cmd_addr=0x000000; after cmd_ack, fetch_en=1.
- No pops, 4 word_valid pulses → occupancy=4, fetch_en=0 in the cycle the 4th word lands; one pop → fetch_en=1 next cycle.
- VIDEO_WORDS=8: stream 8 words → cmd_stop pulse, cmd_ack → IDLE, loop_cnt=1, cmd_addr=BASE_ADDR; next frame_start restarts at 0x000000.
- Drop enable after word 5 (BASE 0) → cmd_stop, IDLE; re-enable + frame_start → cmd_start with cmd_addr=0x00000F.
- Pop while occupancy=0 → underrun=1, occupancy stays 0, underrun persists; simultaneous pop+valid at 0 → no underrun.
- Assert rst_n=0 during STREAM with occupancy=3 → all outputs to reset values immediately (async), no cmd_stop emitted.
